// File: rtl/jtgng_romarb.sv
// ROM read arbiter: shares one SDRAM read port among N ROM requesters and
//   holds one returned word per requester. req_ok[i] is high while that word
//   matches the address requester i currently presents.
// Ports: req_cs/req_addr   per-requester chip-select and packed word address
//        req_ok/req_data   per-requester hit flag and packed held data
//        sdram_*           request/ack/ready handshake to the SDRAM controller
//        grant_id/busy     requester being served, FSM active
//        timeout_err       sticky watchdog abort flag
// Latency: grant one cycle after a requester becomes pending; req_ok rises
//   the cycle after sdram_rdy. Backpressure: sdram_req/sdram_addr are held
//   until sdram_ack. A missing sdram_rdy is aborted after TIMEOUT cycles.
// Build option: define JTGNG_ROMARB_CACHE_EN to keep held words across
//   chip-select deassertion.
module jtgng_romarb #(
  parameter int N       = 5,
  parameter int AW      = 22,
  parameter int DW      = 16,
  parameter int PRIO    = 0,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req_cs,
  input  logic [N*AW-1:0] req_addr,
  output logic [N-1:0]    req_ok,
  output logic [N*DW-1:0] req_data,
  output logic            sdram_req,
  output logic [AW-1:0]   sdram_addr,
  input  logic            sdram_ack,
  input  logic            sdram_rdy,
  input  logic [DW-1:0]   sdram_din,
  output logic [2:0]      grant_id,
  output logic            busy,
  output logic            timeout_err
);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DATA} state_t;

  state_t        state;
  logic [AW-1:0] addr_reg [N];
  logic [N-1:0]  valid;
  logic [N-1:0]  pending;
  logic [2:0]    last_grant;
  logic [2:0]    next_g;
  logic          next_vld;
  logic [7:0]    wd;
  logic          store;
  int            idx;

  assign busy  = (state != IDLE);
  assign store = (state == WAIT_DATA) && sdram_rdy;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_ok[i]  = req_cs[i] & valid[i] & (addr_reg[i] == req_addr[i*AW +: AW]);
      pending[i] = req_cs[i] & ~req_ok[i];
    end
  end

  // PRIO wins outright; otherwise round-robin starting just after the last
  // non-PRIO grant, with PRIO excluded from the rotation.
  always_comb begin
    next_vld = 1'b0;
    next_g   = 3'(PRIO);
    idx      = 0;
    if (pending[PRIO]) begin
      next_vld = 1'b1;
    end else begin
      for (int k = 1; k <= N; k++) begin
        idx = int'(last_grant) + k;
        if (idx >= N) idx = idx - N;
        if (!next_vld && idx != PRIO && pending[idx]) begin
          next_vld = 1'b1;
          next_g   = 3'(idx);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sdram_req   <= 1'b0;
      sdram_addr  <= '0;
      grant_id    <= 3'd0;
      last_grant  <= 3'(N-1);
      timeout_err <= 1'b0;
      wd          <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (next_vld) begin
            sdram_addr <= req_addr[int'(next_g)*AW +: AW];
            grant_id   <= next_g;
            if (int'(next_g) != PRIO) last_grant <= next_g;
            sdram_req  <= 1'b1;
            state      <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          // A same-cycle sdram_rdy is deliberately ignored here.
          if (sdram_ack) begin
            sdram_req <= 1'b0;
            wd        <= 8'd0;
            state     <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (sdram_rdy) begin
            state <= IDLE;
          end else if (wd == 8'(TIMEOUT-1)) begin
            state       <= IDLE;
            timeout_err <= 1'b1;
          end else begin
            wd <= wd + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Held words are tagged with the latched fetch address, so a requester that
  // moved on mid-fetch simply misses and gets queued again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid    <= '0;
      req_data <= '0;
      for (int i = 0; i < N; i++) addr_reg[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (store && grant_id == 3'(i)) begin
          req_data[i*DW +: DW] <= sdram_din;
          addr_reg[i]          <= sdram_addr;
        end
`ifdef JTGNG_ROMARB_CACHE_EN
        if (store && grant_id == 3'(i)) valid[i] <= 1'b1;
`else
        // Deselect wins over a same-cycle store: every new cs starts fresh.
        if (!req_cs[i])                      valid[i] <= 1'b0;
        else if (store && grant_id == 3'(i)) valid[i] <= 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_jtgng_romarb.sv
// Directed bench for jtgng_romarb: a hand-driven SDRAM controller serves
// each grant; expected grant order, addresses, data and flags are written
// out per step.
module tb_jtgng_romarb;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [4:0]   req_cs = '0;
  logic [109:0] req_addr = '0;
  logic [4:0]   req_ok;
  logic [79:0]  req_data;
  logic         sdram_req;
  logic [21:0]  sdram_addr;
  logic         sdram_ack = 1'b0;
  logic         sdram_rdy = 1'b0;
  logic [15:0]  sdram_din = '0;
  logic [2:0]   grant_id;
  logic         busy;
  logic         timeout_err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  jtgng_romarb dut (
    .clk(clk), .rst_n(rst_n), .req_cs(req_cs), .req_addr(req_addr),
    .req_ok(req_ok), .req_data(req_data), .sdram_req(sdram_req),
    .sdram_addr(sdram_addr), .sdram_ack(sdram_ack), .sdram_rdy(sdram_rdy),
    .sdram_din(sdram_din), .grant_id(grant_id), .busy(busy),
    .timeout_err(timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a request, then check who was granted and where.
  task automatic grant_chk(input logic [2:0] g, input logic [21:0] a);
    int n = 0;
    while (!sdram_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("sdram_req", 32'(sdram_req), 32'd1);
    check("grant_id", 32'(grant_id), 32'(g));
    check("sdram_addr", 32'(sdram_addr), 32'(a));
  endtask

  // Ack immediately, then return the word one cycle later.
  task automatic complete(input logic [15:0] d);
    sdram_ack = 1'b1;
    @(negedge clk);
    sdram_ack = 1'b0;
    sdram_rdy = 1'b1;
    sdram_din = d;
    @(negedge clk);
    sdram_rdy = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_req", 32'(sdram_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data", req_data[31:0], 32'd0);
    check("rst_terr", 32'(timeout_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Stray rdy in IDLE stores nothing
    sdram_rdy = 1'b1; sdram_din = 16'h5555;
    @(negedge clk);
    sdram_rdy = 1'b0;
    check("stray_rdy", req_data[31:0], 32'd0);

    // Single fetch: ack after 2 cycles, data 3 cycles after that
    req_cs = 5'b00001;
    req_addr[0*22 +: 22] = 22'h000100;
    @(negedge clk);
    check("sf_req", 32'(sdram_req), 32'd1);
    check("sf_addr", 32'(sdram_addr), 32'h100);
    check("sf_busy", 32'(busy), 32'd1);
    @(negedge clk);
    sdram_ack = 1'b1;
    @(negedge clk);
    sdram_ack = 1'b0;
    check("sf_req_drop", 32'(sdram_req), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("sf_ok_early", 32'(req_ok), 32'd0);
    sdram_rdy = 1'b1; sdram_din = 16'hBEEF;
    @(negedge clk);
    sdram_rdy = 1'b0;
    check("sf_ok", 32'(req_ok), 32'b00001);
    check("sf_data", 32'(req_data[0*16 +: 16]), 32'hBEEF);

    // Round-robin over 1..4
    req_cs = 5'b11110;
    req_addr[1*22 +: 22] = 22'h11;
    req_addr[2*22 +: 22] = 22'h12;
    req_addr[3*22 +: 22] = 22'h13;
    req_addr[4*22 +: 22] = 22'h14;
    grant_chk(3'd1, 22'h11); complete(16'hA001);
    grant_chk(3'd2, 22'h12); complete(16'hA002);
    grant_chk(3'd3, 22'h13); complete(16'hA003);
    grant_chk(3'd4, 22'h14); complete(16'hA004);
    check("rr_ok", 32'(req_ok), 32'b11110);
    check("rr_data1", 32'(req_data[1*16 +: 16]), 32'hA001);
    check("rr_data4", 32'(req_data[4*16 +: 16]), 32'hA004);
    req_addr[2*22 +: 22] = 22'h22;
    req_addr[3*22 +: 22] = 22'h23;
    grant_chk(3'd2, 22'h22); complete(16'hB002);
    grant_chk(3'd3, 22'h23); complete(16'hB003);
    check("rr2_ok", 32'(req_ok), 32'b11110);
    check("rr2_data3", 32'(req_data[3*16 +: 16]), 32'hB003);

    // Priority pre-emption (last grant was 3, so 4 then 1 wraps first)
    req_addr[1*22 +: 22] = 22'h31;
    req_addr[2*22 +: 22] = 22'h32;
    req_addr[3*22 +: 22] = 22'h33;
    req_addr[4*22 +: 22] = 22'h34;
    grant_chk(3'd4, 22'h34); complete(16'hC004);
    grant_chk(3'd1, 22'h31);
    req_cs = 5'b11111;
    req_addr[0*22 +: 22] = 22'h30;
    complete(16'hC001);
    grant_chk(3'd0, 22'h30); complete(16'hC000);
    grant_chk(3'd2, 22'h32); complete(16'hC002);
    grant_chk(3'd3, 22'h33); complete(16'hC003);
    check("pp_ok", 32'(req_ok), 32'b11111);
    check("pp_data0", 32'(req_data[0*16 +: 16]), 32'hC000);

    // Address change mid-fetch
    req_addr[2*22 +: 22] = 22'h10;
    grant_chk(3'd2, 22'h10);
    sdram_ack = 1'b1;
    @(negedge clk);
    sdram_ack = 1'b0;
    req_addr[2*22 +: 22] = 22'h20;
    sdram_rdy = 1'b1; sdram_din = 16'hD010;
    @(negedge clk);
    sdram_rdy = 1'b0;
    check("ac_ok_low", 32'(req_ok[2]), 32'd0);
    grant_chk(3'd2, 22'h20); complete(16'hD020);
    check("ac_ok", 32'(req_ok[2]), 32'd1);
    check("ac_data", 32'(req_data[2*16 +: 16]), 32'hD020);

    // Cache behaviour on cs drop / re-assert
    req_addr[3*22 +: 22] = 22'h40;
    grant_chk(3'd3, 22'h40); complete(16'hE040);
    check("ca_ok", 32'(req_ok[3]), 32'd1);
    req_cs = 5'b10111;
    repeat (5) @(negedge clk);
    check("ca_idle_req", 32'(sdram_req), 32'd0);
    req_cs = 5'b11111;
    #1;
`ifdef JTGNG_ROMARB_CACHE_EN
    check("ca_hit", 32'(req_ok[3]), 32'd1);
    @(negedge clk);
    check("ca_no_req", 32'(sdram_req), 32'd0);
    check("ca_data", 32'(req_data[3*16 +: 16]), 32'hE040);
`else
    check("ca_miss", 32'(req_ok[3]), 32'd0);
    @(negedge clk);
    grant_chk(3'd3, 22'h40); complete(16'hE041);
    check("ca_refetch", 32'(req_data[3*16 +: 16]), 32'hE041);
`endif

    // Watchdog: ack but never rdy
    req_addr[4*22 +: 22] = 22'h50;
    grant_chk(3'd4, 22'h50);
    sdram_ack = 1'b1;
    @(negedge clk);
    sdram_ack = 1'b0;
    repeat (254) @(negedge clk);
    check("to_busy", 32'(busy), 32'd1);
    check("to_err_early", 32'(timeout_err), 32'd0);
    @(negedge clk);
    check("to_idle", 32'(busy), 32'd0);
    check("to_err", 32'(timeout_err), 32'd1);
    check("to_ok", 32'(req_ok), 32'b01111);
    check("to_data4", 32'(req_data[4*16 +: 16]), 32'hC004);

    // Retry, then asynchronous reset in WAIT_DATA
    grant_chk(3'd4, 22'h50);
    sdram_ack = 1'b1;
    @(negedge clk);
    sdram_ack = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_addr", 32'(sdram_addr), 32'd0);
    check("ar_terr", 32'(timeout_err), 32'd0);
    check("ar_ok", 32'(req_ok), 32'd0);
    check("ar_data", req_data[31:0], 32'd0);
    check("ar_gid", 32'(grant_id), 32'd0);
    req_cs = 5'b00000;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // After reset, rotation starts just after N-1
    req_cs = 5'b00110;
    req_addr[1*22 +: 22] = 22'h61;
    req_addr[2*22 +: 22] = 22'h62;
    grant_chk(3'd1, 22'h61); complete(16'hF061);
    grant_chk(3'd2, 22'h62); complete(16'hF062);
    check("pr_ok", 32'(req_ok), 32'b00110);
    check("pr_data2", 32'(req_data[2*16 +: 16]), 32'hF062);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
